mem_stage: RTL and testbench

Memory stage of the five-stage pipeline, between the X/M pipeline register and the writeback stage. Consumes the X/M register outputs and drives a variable-latency data-memory request/done handshake. Freezes upstream stages while an access is outstanding, flags unaligned and timed-out accesses, and contains the M/W pipeline register that feeds writeback.

---
 rtl/mem_stage_pkg.sv | 17 +
 rtl/mem_stage_if.sv | 7 +
 rtl/mem_stage_mw_pipe.sv | 12 +
 rtl/mem_stage.sv | 87 ++++++++
 tb/tb_mem_stage.sv | 186 ++++++++++++++++++
 5 files changed

// File: rtl/mem_stage_pkg.sv
// mem_stage_pkg: shared state encoding, register-source codes and M/W record types
package mem_stage_pkg;
   typedef enum logic {MS_IDLE, MS_WAIT} ms_state_e;
   typedef enum logic [1:0] {RS_ALU, RS_MEM, RS_PC, RS_SPEC} reg_src_e;
   localparam int TIMEOUT_DEF = 64;
   typedef struct packed {
      logic [15:0] instr, read_data, alu_out, pc_inc, spec_ops;
      logic [1:0]  reg_src;
      logic        reg_write;
      logic [2:0]  write_reg;
      logic        halt, err;
   } mw_t;
   typedef struct packed {
      logic        wr;
      logic [15:0] addr, wdata;
   } req_t;
endpackage

// File: rtl/mem_stage_if.sv
// mem_stage_if: variable-latency data-memory request/done handshake
interface mem_stage_if;
   logic        mem_req, mem_wr, mem_done;
   logic [15:0] mem_addr, mem_wdata, mem_rdata;
   modport master(output mem_req, mem_wr, mem_addr, mem_wdata, input mem_done, mem_rdata);
   modport slave(input mem_req, mem_wr, mem_addr, mem_wdata, output mem_done, mem_rdata);
endinterface

// File: rtl/mem_stage_mw_pipe.sv
// mw_pipe: M/W pipeline register bank, loads whenever the stage is not stalled
module mw_pipe import mem_stage_pkg::*; (
   input  logic clk,
   input  logic rst,
   input  logic en,
   input  mw_t  d,
   output mw_t  q
);
   always_ff @(posedge clk or negedge rst)
      if (!rst) q <= '0;
      else if (en) q <= d;
endmodule

// File: rtl/mem_stage.sv
// mem_stage: memory stage with request FSM, wait timeout, alignment check and M/W register
module mem_stage import mem_stage_pkg::*; #(
   parameter int TIMEOUT = TIMEOUT_DEF
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [15:0] XM_instr,
   input  logic [15:0] XM_aluOut,
   input  logic [15:0] XM_writeData,
   input  logic [15:0] XM_pc_inc,
   input  logic [15:0] XM_specOps,
   input  logic        XM_memRead,
   input  logic        XM_memWrite,
   input  logic [1:0]  XM_regSrc,
   input  logic        XM_regWrite,
   input  logic [2:0]  XM_writeReg,
   input  logic        XM_halt,
   mem_stage_if.master mem,
   output logic        stall,
   output logic [15:0] MW_instr,
   output logic [15:0] MW_readData,
   output logic [15:0] MW_aluOut,
   output logic [15:0] MW_pc_inc,
   output logic [15:0] MW_specOps,
   output logic [1:0]  MW_regSrc,
   output logic        MW_regWrite,
   output logic [2:0]  MW_writeReg,
   output logic        MW_halt,
   output logic        MW_err
);
   localparam int CW = $clog2(TIMEOUT);
   ms_state_e state_q, state_d;
   logic [CW-1:0] cnt_q, cnt_d;
   req_t req_q, req_d, xm_req, cur_req;
   mw_t pl_q, pl_d, xm, cur, mw_d, mw_q;
   logic waiting, access, unaligned, timeout, req;
   always_comb begin
      xm = '{instr: XM_instr, read_data: 16'h0, alu_out: XM_aluOut, pc_inc: XM_pc_inc,
             spec_ops: XM_specOps, reg_src: XM_regSrc, reg_write: XM_regWrite,
             write_reg: XM_writeReg, halt: XM_halt, err: 1'b0};
      xm_req = '{wr: XM_memWrite, addr: XM_aluOut, wdata: XM_writeData};
      waiting = state_q == MS_WAIT;
      access = ~waiting & (XM_memRead | XM_memWrite);
      unaligned = access & XM_aluOut[0];
      // abort on the last allowed wait cycle so the request never sees TIMEOUT cycles
      timeout = waiting & ~mem.mem_done & (cnt_q == CW'(TIMEOUT - 2));
      req = rst & (waiting ? ~timeout : access & ~XM_aluOut[0]);
      stall = req & ~mem.mem_done;
      cur_req = waiting ? req_q : xm_req;
      cur = waiting ? pl_q : xm;
      mw_d = cur;
      mw_d.read_data = (req & mem.mem_done & ~cur_req.wr) ? mem.mem_rdata : 16'h0;
      mw_d.err = unaligned | timeout;
      mw_d.reg_write = cur.reg_write & ~(unaligned | timeout);
      state_d = stall ? MS_WAIT : MS_IDLE;
      cnt_d = waiting ? cnt_q + 1'b1 : '0;
      req_d = (stall & ~waiting) ? xm_req : req_q;
      pl_d = (stall & ~waiting) ? xm : pl_q;
   end
   always_ff @(posedge clk or negedge rst)
      if (!rst) begin
         state_q <= MS_IDLE;
         cnt_q <= '0;
         req_q <= '0;
         pl_q <= '0;
      end else begin
         state_q <= state_d;
         cnt_q <= cnt_d;
         req_q <= req_d;
         pl_q <= pl_d;
      end
   assign mem.mem_req = req;
   assign mem.mem_wr = cur_req.wr;
   assign mem.mem_addr = cur_req.addr;
   assign mem.mem_wdata = cur_req.wdata;
   mw_pipe u_mw (.clk(clk), .rst(rst), .en(~stall), .d(mw_d), .q(mw_q));
   assign MW_instr = mw_q.instr;
   assign MW_readData = mw_q.read_data;
   assign MW_aluOut = mw_q.alu_out;
   assign MW_pc_inc = mw_q.pc_inc;
   assign MW_specOps = mw_q.spec_ops;
   assign MW_regSrc = mw_q.reg_src;
   assign MW_regWrite = mw_q.reg_write;
   assign MW_writeReg = mw_q.write_reg;
   assign MW_halt = mw_q.halt;
   assign MW_err = mw_q.err;
endmodule

// File: tb/tb_mem_stage.sv
// tb_mem_stage: directed vectors and multi-cycle sequences for mem_stage with TIMEOUT = 4
module tb_mem_stage;
   logic clk, rst;
   logic [15:0] XM_instr, XM_aluOut, XM_writeData, XM_pc_inc, XM_specOps;
   logic XM_memRead, XM_memWrite, XM_regWrite, XM_halt;
   logic [1:0] XM_regSrc;
   logic [2:0] XM_writeReg;
   logic stall, MW_regWrite, MW_halt, MW_err;
   logic [15:0] MW_instr, MW_readData, MW_aluOut, MW_pc_inc, MW_specOps;
   logic [1:0] MW_regSrc;
   logic [2:0] MW_writeReg;
   int n_chk, n_pass, ns;
   mem_stage_if bus();
   mem_stage #(.TIMEOUT(4)) dut (
      .clk(clk), .rst(rst), .XM_instr(XM_instr), .XM_aluOut(XM_aluOut),
      .XM_writeData(XM_writeData), .XM_pc_inc(XM_pc_inc), .XM_specOps(XM_specOps),
      .XM_memRead(XM_memRead), .XM_memWrite(XM_memWrite), .XM_regSrc(XM_regSrc),
      .XM_regWrite(XM_regWrite), .XM_writeReg(XM_writeReg), .XM_halt(XM_halt),
      .mem(bus.master), .stall(stall), .MW_instr(MW_instr), .MW_readData(MW_readData),
      .MW_aluOut(MW_aluOut), .MW_pc_inc(MW_pc_inc), .MW_specOps(MW_specOps),
      .MW_regSrc(MW_regSrc), .MW_regWrite(MW_regWrite), .MW_writeReg(MW_writeReg),
      .MW_halt(MW_halt), .MW_err(MW_err)
   );
   initial clk = 1'b0;
   always #5 clk = ~clk;
   typedef struct {
      logic [15:0] ins, alu, wd;
      logic rd, wr, rw, done;
      logic [15:0] rdata;
      logic ereq, ewr;
      logic [15:0] erd;
      logic eerr, erw;
   } vec_t;
   vec_t v[8];
   task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
      n_chk++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %h expected %h", nm, act, exp);
   endtask
   task automatic set_xm(input logic [15:0] ins, input logic [15:0] alu, input logic [15:0] wd,
                         input logic rd, input logic wr, input logic rw);
      XM_instr = ins; XM_aluOut = alu; XM_writeData = wd; XM_pc_inc = ins + 16'd2;
      XM_specOps = ~ins; XM_memRead = rd; XM_memWrite = wr; XM_regWrite = rw;
      XM_regSrc = 2'd1; XM_writeReg = ins[2:0]; XM_halt = ins[15];
   endtask
   initial begin
      n_chk = 0; n_pass = 0;
      v[0] = '{16'h1111, 16'h0042, 16'h0000, 0, 0, 1, 0, 16'h0000, 0, 0, 16'h0000, 0, 1};
      v[1] = '{16'h1212, 16'h0044, 16'h0000, 0, 0, 1, 1, 16'hAAAA, 0, 0, 16'h0000, 0, 1};
      v[2] = '{16'h2222, 16'h0010, 16'h0000, 1, 0, 1, 1, 16'hBEEF, 1, 0, 16'hBEEF, 0, 1};
      v[3] = '{16'h3333, 16'h0030, 16'h5678, 0, 1, 0, 1, 16'h9999, 1, 1, 16'h0000, 0, 0};
      v[4] = '{16'h4141, 16'h0021, 16'h0000, 1, 0, 1, 0, 16'h0000, 0, 0, 16'h0000, 1, 0};
      v[5] = '{16'h5151, 16'h0033, 16'h0001, 0, 1, 0, 1, 16'h7777, 0, 0, 16'h0000, 1, 0};
      v[6] = '{16'hE161, 16'h0034, 16'h0002, 1, 1, 1, 1, 16'h5555, 1, 1, 16'h0000, 0, 1};
      v[7] = '{16'h7171, 16'h0008, 16'h0000, 0, 0, 1, 0, 16'h0000, 0, 0, 16'h0000, 0, 1};
      rst = 1'b0;
      set_xm(16'h0, 16'h0, 16'h0, 0, 0, 0);
      bus.mem_done = 1'b0; bus.mem_rdata = 16'h0;
      #1;
      chk("rst_req", bus.mem_req, 0); chk("rst_stall", stall, 0);
      chk("rst_instr", MW_instr, 0); chk("rst_err", MW_err, 0); chk("rst_rw", MW_regWrite, 0);
      @(negedge clk); @(negedge clk); rst = 1'b1;
      for (int i = 0; i < 8; i++) begin
         @(negedge clk);
         set_xm(v[i].ins, v[i].alu, v[i].wd, v[i].rd, v[i].wr, v[i].rw);
         bus.mem_done = v[i].done; bus.mem_rdata = v[i].rdata;
         #1;
         chk($sformatf("v%0d_req", i), bus.mem_req, v[i].ereq);
         chk($sformatf("v%0d_stall", i), stall, 0);
         if (v[i].ereq) begin
            chk($sformatf("v%0d_wr", i), bus.mem_wr, v[i].ewr);
            chk($sformatf("v%0d_addr", i), bus.mem_addr, v[i].alu);
            chk($sformatf("v%0d_wdata", i), bus.mem_wdata, v[i].wd);
         end
         @(posedge clk); #1;
         chk($sformatf("v%0d_instr", i), MW_instr, v[i].ins);
         chk($sformatf("v%0d_rdata", i), MW_readData, v[i].erd);
         chk($sformatf("v%0d_err", i), MW_err, v[i].eerr);
         chk($sformatf("v%0d_rw", i), MW_regWrite, v[i].erw);
         chk($sformatf("v%0d_alu", i), MW_aluOut, v[i].alu);
         chk($sformatf("v%0d_pc", i), MW_pc_inc, v[i].ins + 16'd2);
         chk($sformatf("v%0d_spec", i), MW_specOps, ~v[i].ins);
         chk($sformatf("v%0d_wreg", i), MW_writeReg, v[i].ins[2:0]);
         chk($sformatf("v%0d_halt", i), MW_halt, v[i].ins[15]);
         chk($sformatf("v%0d_rsrc", i), MW_regSrc, 2'd1);
      end
      // store with done on the third request cycle; X/M bus scrambled while stalled
      @(negedge clk);
      bus.mem_done = 1'b0;
      set_xm(16'hA0A0, 16'h0020, 16'h1234, 0, 1, 0);
      ns = 0;
      for (int c = 0; c < 3; c++) begin
         if (c == 2) begin bus.mem_done = 1'b1; bus.mem_rdata = 16'hFFFF; end
         #1;
         ns += int'(stall);
         chk("st_req", bus.mem_req, 1); chk("st_wr", bus.mem_wr, 1);
         chk("st_addr", bus.mem_addr, 16'h0020); chk("st_wdata", bus.mem_wdata, 16'h1234);
         if (c == 1) chk("st_mw_hold", MW_instr, 16'h7171);
         @(posedge clk); #1;
         if (c == 0) begin XM_aluOut = 16'hDEAD; XM_writeData = 16'hDEAD; end
         @(negedge clk);
      end
      chk("st_stall_cycles", 16'(ns), 16'd2);
      chk("st_mw_instr", MW_instr, 16'hA0A0); chk("st_mw_alu", MW_aluOut, 16'h0020);
      chk("st_mw_rdata", MW_readData, 16'h0); chk("st_mw_err", MW_err, 0);
      bus.mem_done = 1'b0;
      // timeout: done never arrives
      set_xm(16'h4444, 16'h0040, 16'h0, 1, 0, 1);
      ns = 0;
      for (int c = 0; c < 10; c++) begin
         #1;
         if (!stall) break;
         ns++;
         @(negedge clk);
      end
      chk("to_stall_cycles", 16'(ns), 16'd3);
      chk("to_req_drop", bus.mem_req, 0);
      @(posedge clk); #1;
      chk("to_err", MW_err, 1); chk("to_rw", MW_regWrite, 0); chk("to_instr", MW_instr, 16'h4444);
      @(negedge clk);
      set_xm(16'h5555, 16'h0007, 16'h0, 0, 0, 1);
      #1;
      chk("to_next_req", bus.mem_req, 0); chk("to_next_stall", stall, 0);
      @(posedge clk); #1;
      chk("to_next_instr", MW_instr, 16'h5555); chk("to_next_err", MW_err, 0);
      chk("to_next_rw", MW_regWrite, 1);
      // reset while waiting
      @(negedge clk);
      set_xm(16'hC0C0, 16'h0050, 16'h0, 1, 0, 1);
      @(posedge clk); #2;
      chk("rw_pre_stall", stall, 1);
      rst = 1'b0;
      #1;
      chk("rw_req", bus.mem_req, 0); chk("rw_stall", stall, 0);
      chk("rw_instr", MW_instr, 0); chk("rw_alu", MW_aluOut, 0); chk("rw_pc", MW_pc_inc, 0);
      chk("rw_spec", MW_specOps, 0); chk("rw_rw", MW_regWrite, 0);
      @(negedge clk);
      set_xm(16'h0101, 16'h0000, 16'h0, 0, 0, 0);
      rst = 1'b1;
      #1;
      chk("rw_no_retry", bus.mem_req, 0);
      @(negedge clk);
      set_xm(16'hD0D0, 16'h0060, 16'h0, 1, 0, 1);
      #1;
      chk("rl_stall0", stall, 1);
      @(negedge clk);
      bus.mem_done = 1'b1; bus.mem_rdata = 16'hCAFE;
      #1;
      chk("rl_stall1", stall, 0); chk("rl_req", bus.mem_req, 1); chk("rl_addr", bus.mem_addr, 16'h0060);
      @(posedge clk); #1;
      chk("rl_rdata", MW_readData, 16'hCAFE); chk("rl_instr", MW_instr, 16'hD0D0); chk("rl_err", MW_err, 0);
      // back-to-back: ALU, load waiting 2 cycles, ALU, ALU
      @(negedge clk);
      bus.mem_done = 1'b0;
      set_xm(16'h6666, 16'h0003, 16'h0, 0, 0, 1);
      @(posedge clk); #1;
      chk("bb_first", MW_instr, 16'h6666);
      @(negedge clk);
      set_xm(16'h7777, 16'h0070, 16'h0, 1, 0, 1);
      #1;
      chk("bb_stall0", stall, 1);
      @(negedge clk);
      #1;
      chk("bb_stall1", stall, 1); chk("bb_hold", MW_instr, 16'h6666);
      @(negedge clk);
      bus.mem_done = 1'b1; bus.mem_rdata = 16'h0BAD;
      #1;
      chk("bb_stall2", stall, 0);
      @(posedge clk); #1;
      chk("bb_ld_instr", MW_instr, 16'h7777); chk("bb_ld_rdata", MW_readData, 16'h0BAD);
      @(negedge clk);
      bus.mem_done = 1'b0;
      set_xm(16'h8888, 16'h0005, 16'h0, 0, 0, 1);
      #1;
      chk("bb_alu_stall", stall, 0);
      @(posedge clk); #1;
      chk("bb_alu_instr", MW_instr, 16'h8888); chk("bb_alu_rdata", MW_readData, 16'h0);
      chk("bb_alu_alu", MW_aluOut, 16'h0005);
      @(negedge clk);
      set_xm(16'h9999, 16'h0006, 16'h0, 0, 0, 1);
      @(posedge clk); #1;
      chk("bb_next_instr", MW_instr, 16'h9999);
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end
endmodule
